gppcu_regbank_wr_arbiter: RTL and testbench

Write-port arbiter and sequencer for the GPPCU per-thread register bank. The register bank exposes a single write port (select, data, write strobe). This block shares that port between three requesters:
- pipeline writeback, which cannot stall;
- memory load returns, buffered in a small FIFO;
- a host configuration port for register preload and patching.

It also exports a pending-load scoreboard so the issue stage can stall on load hazards.

---
 rtl/gppcu_regbank_wr_arbiter_pkg.sv | 29 ++
 rtl/gppcu_wr_fifo.sv | 72 +++++++
 rtl/gppcu_regbank_wr_arbiter.sv | 127 ++++++++++++
 tb/tb_gppcu_regbank_wr_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gppcu_regbank_wr_arbiter_pkg.sv
// Shared types for the GPPCU register-bank write arbiter.
// Grant encoding, bank field widths and the select decoder.
package gppcu_regbank_wr_arbiter_pkg;

    localparam int SEL_W  = 5;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB   = 2'd1,
        GNT_LD   = 2'd2,
        GNT_HOST = 2'd3
    } gnt_e;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } wrReq_t;

    function automatic logic [DATA_W-1:0] selDecode(
        input logic [SEL_W-1:0] sel
    );
        logic [DATA_W-1:0] oneHot;
        oneHot      = '0;
        oneHot[sel] = 1'b1;
        return oneHot;
    endfunction

endpackage

// File: rtl/gppcu_wr_fifo.sv
// Load-return FIFO with per-entry valid bits and selects exposed
// so the parent can build the pending-load scoreboard.
module gppcu_wr_fifo
    import gppcu_regbank_wr_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       iACLK,
    input  logic                       iARESETn,
    input  logic                       push,
    input  logic [SEL_W-1:0]           pushSel,
    input  logic [DATA_W-1:0]          pushData,
    input  logic                       pop,
    output logic [SEL_W-1:0]           headSel,
    output logic [DATA_W-1:0]          headData,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic [DEPTH-1:0]           entValid,
    output logic [DEPTH*SEL_W-1:0]     entSel
);

    localparam int AW = $clog2(DEPTH);

    wrReq_t           mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      rCount;
    logic [DEPTH-1:0] rVld;
    logic [DEPTH-1:0] vldNxt;

    always_comb begin
        vldNxt = rVld;
        if (pop)  vldNxt[rdPtr] = 1'b0;
        if (push) vldNxt[wrPtr] = 1'b1;
    end

    always_ff @(posedge iACLK or negedge iARESETn) begin
        if (!iARESETn) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            rCount <= '0;
            rVld   <= '0;
        end else begin
            rVld <= vldNxt;
            if (push) wrPtr <= wrPtr + AW'(1);
            if (pop)  rdPtr <= rdPtr + AW'(1);
            case ({push, pop})
                2'b10:   rCount <= rCount + (AW+1)'(1);
                2'b01:   rCount <= rCount - (AW+1)'(1);
                default: rCount <= rCount;
            endcase
        end
    end

    // Payload storage needs no reset; validity lives in rVld.
    always_ff @(posedge iACLK) begin
        if (push) mem[wrPtr] <= '{sel: pushSel, data: pushData};
    end

    assign headSel  = mem[rdPtr].sel;
    assign headData = mem[rdPtr].data;
    assign count    = rCount;
    assign full     = (rCount == (AW+1)'(DEPTH));
    assign empty    = (rCount == '0);
    assign entValid = rVld;

    for (genvar i = 0; i < DEPTH; i++) begin : gSel
        assign entSel[i*SEL_W +: SEL_W] = mem[i].sel;
    end

endmodule

// File: rtl/gppcu_regbank_wr_arbiter.sv
// Shares the register-bank write port between writeback, load
// returns and host config; exports the pending-load scoreboard.
module gppcu_regbank_wr_arbiter
    import gppcu_regbank_wr_arbiter_pkg::*;
#(
    parameter int LD_DEPTH = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                      iACLK,
    input  logic                      iARESETn,
    input  logic                      iWB_VALID,
    input  logic [4:0]                iWB_SEL,
    input  logic [31:0]               iWB_DATA,
    input  logic                      iLD_VALID,
    output logic                      oLD_READY,
    input  logic [4:0]                iLD_SEL,
    input  logic [31:0]               iLD_DATA,
    input  logic                      iHOST_VALID,
    output logic                      oHOST_READY,
    input  logic [4:0]                iHOST_SEL,
    input  logic [31:0]               iHOST_DATA,
    output logic                      oWR,
    output logic [4:0]                oREGDSEL,
    output logic [31:0]               oREGD,
    output logic [1:0]                oGNT,
    output logic [31:0]               oLDPEND,
    output logic [$clog2(LD_DEPTH):0] oLD_COUNT
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    logic                      rRun;
    logic [WW-1:0]             rWait;
    gnt_e                      gnt;
    logic                      starved;
    logic                      push;
    logic                      pop;
    logic                      fifoFull;
    logic                      fifoEmpty;
    logic [SEL_W-1:0]          headSel;
    logic [DATA_W-1:0]         headData;
    logic [LD_DEPTH-1:0]       entValid;
    logic [LD_DEPTH*SEL_W-1:0] entSel;

    gppcu_wr_fifo #(.DEPTH(LD_DEPTH)) uFifo (
        .iACLK    (iACLK),
        .iARESETn (iARESETn),
        .push     (push),
        .pushSel  (iLD_SEL),
        .pushData (iLD_DATA),
        .pop      (pop),
        .headSel  (headSel),
        .headData (headData),
        .count    (oLD_COUNT),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .entValid (entValid),
        .entSel   (entSel)
    );

    assign oLD_READY = rRun && !fifoFull;
    assign push      = iLD_VALID && oLD_READY;
    assign starved   = (rWait == WW'(MAX_WAIT));

    always_comb begin
        gnt = GNT_NONE;
        if (rRun) begin
            if (iWB_VALID)
                gnt = GNT_WB;
            else if (!fifoEmpty && !(starved && iHOST_VALID))
                gnt = GNT_LD;
            else if (iHOST_VALID)
                gnt = GNT_HOST;
        end
    end

    assign pop         = (gnt == GNT_LD);
    assign oGNT        = gnt;
    assign oHOST_READY = (gnt == GNT_HOST);

    // Combinational mux keeps the bank's same-cycle bypass valid.
    always_comb begin
        oWR      = 1'b0;
        oREGDSEL = '0;
        oREGD    = '0;
        unique case (gnt)
            GNT_WB: begin
                oWR      = 1'b1;
                oREGDSEL = iWB_SEL;
                oREGD    = iWB_DATA;
            end
            GNT_LD: begin
                oWR      = 1'b1;
                oREGDSEL = headSel;
                oREGD    = headData;
            end
            GNT_HOST: begin
                oWR      = 1'b1;
                oREGDSEL = iHOST_SEL;
                oREGD    = iHOST_DATA;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iACLK or negedge iARESETn) begin
        if (!iARESETn) begin
            rRun  <= 1'b0;
            rWait <= '0;
        end else begin
            rRun <= 1'b1;
            if (!iHOST_VALID || gnt == GNT_HOST)
                rWait <= '0;
            else if (!starved)
                rWait <= rWait + WW'(1);
        end
    end

    always_comb begin
        oLDPEND = '0;
        for (int i = 0; i < LD_DEPTH; i++) begin
            if (entValid[i])
                oLDPEND = oLDPEND | selDecode(entSel[i*SEL_W +: SEL_W]);
        end
    end

endmodule

// File: tb/tb_gppcu_regbank_wr_arbiter.sv
// Scoreboard bench for the register-bank write arbiter.
// Expected writes are queued by stimulus, popped by the monitor.
module tb_gppcu_regbank_wr_arbiter;

    logic        iACLK = 1'b0;
    logic        iARESETn;
    logic        iWB_VALID;
    logic [4:0]  iWB_SEL;
    logic [31:0] iWB_DATA;
    logic        iLD_VALID;
    logic        oLD_READY;
    logic [4:0]  iLD_SEL;
    logic [31:0] iLD_DATA;
    logic        iHOST_VALID;
    logic        oHOST_READY;
    logic [4:0]  iHOST_SEL;
    logic [31:0] iHOST_DATA;
    logic        oWR;
    logic [4:0]  oREGDSEL;
    logic [31:0] oREGD;
    logic [1:0]  oGNT;
    logic [31:0] oLDPEND;
    logic [2:0]  oLD_COUNT;

    typedef struct {
        logic [1:0]  gnt;
        logic [4:0]  sel;
        logic [31:0] data;
    } exp_t;

    exp_t expQ[$];
    int   vectors     = 0;
    int   miscompares = 0;

    gppcu_regbank_wr_arbiter #(.LD_DEPTH(4), .MAX_WAIT(8)) dut (
        .iACLK       (iACLK),
        .iARESETn    (iARESETn),
        .iWB_VALID   (iWB_VALID),
        .iWB_SEL     (iWB_SEL),
        .iWB_DATA    (iWB_DATA),
        .iLD_VALID   (iLD_VALID),
        .oLD_READY   (oLD_READY),
        .iLD_SEL     (iLD_SEL),
        .iLD_DATA    (iLD_DATA),
        .iHOST_VALID (iHOST_VALID),
        .oHOST_READY (oHOST_READY),
        .iHOST_SEL   (iHOST_SEL),
        .iHOST_DATA  (iHOST_DATA),
        .oWR         (oWR),
        .oREGDSEL    (oREGDSEL),
        .oREGD       (oREGD),
        .oGNT        (oGNT),
        .oLDPEND     (oLDPEND),
        .oLD_COUNT   (oLD_COUNT)
    );

    always #5 iACLK = ~iACLK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expWr(input logic [1:0] g, input logic [4:0] s,
                         input logic [31:0] d);
        exp_t e;
        e.gnt  = g;
        e.sel  = s;
        e.data = d;
        expQ.push_back(e);
    endtask

    task automatic tick();
        @(posedge iACLK);
        #1;
    endtask

    task automatic mid();
        @(negedge iACLK);
    endtask

    task automatic idle();
        iWB_VALID   = 1'b0;
        iLD_VALID   = 1'b0;
        iHOST_VALID = 1'b0;
    endtask

    always @(negedge iACLK) begin : mon
        exp_t e;
        if (oWR !== 1'b0) begin
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected write: gnt=%0d sel=%0d data=%h",
                         oGNT, oREGDSEL, oREGD);
            end else begin
                e = expQ.pop_front();
                if (oGNT !== e.gnt || oREGDSEL !== e.sel || oREGD !== e.data) begin
                    miscompares++;
                    $display("FAIL write: got gnt=%0d sel=%0d data=%h expected gnt=%0d sel=%0d data=%h",
                             oGNT, oREGDSEL, oREGD, e.gnt, e.sel, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        iARESETn    = 1'b0;
        iWB_VALID   = 1'b1;
        iWB_SEL     = 5'd1;
        iWB_DATA    = 32'h1;
        iLD_VALID   = 1'b1;
        iLD_SEL     = 5'd2;
        iLD_DATA    = 32'h2;
        iHOST_VALID = 1'b1;
        iHOST_SEL   = 5'd3;
        iHOST_DATA  = 32'h3;

        // reset holds every output quiet even with all requests up
        mid();
        chk("rst oWR", 32'(oWR), 0);
        chk("rst oGNT", 32'(oGNT), 0);
        chk("rst oHOST_READY", 32'(oHOST_READY), 0);
        chk("rst oLD_READY", 32'(oLD_READY), 0);
        chk("rst oLDPEND", oLDPEND, 0);
        chk("rst oLD_COUNT", 32'(oLD_COUNT), 0);
        tick();
        idle();
        iARESETn = 1'b1;
        mid();
        chk("pre-run oLD_READY", 32'(oLD_READY), 0);
        tick();

        // single load: one-cycle latency, pend visible one cycle
        expWr(2'd2, 5'd5, 32'hA5A5A5A5);
        iLD_VALID = 1'b1;
        iLD_SEL   = 5'd5;
        iLD_DATA  = 32'hA5A5A5A5;
        mid();
        chk("t1 oLD_READY", 32'(oLD_READY), 1);
        chk("t1 count before", 32'(oLD_COUNT), 0);
        tick();
        idle();
        mid();
        chk("t1 oLDPEND set", oLDPEND, 32'h20);
        chk("t1 count", 32'(oLD_COUNT), 1);
        chk("t1 oGNT", 32'(oGNT), 2);
        tick();
        mid();
        chk("t1 oLDPEND clear", oLDPEND, 0);
        chk("t1 count drained", 32'(oLD_COUNT), 0);
        tick();

        // WB hogs the port while loads fill the FIFO
        for (int i = 0; i < 6; i++) expWr(2'd1, 5'(10 + i), 32'h1000 + i);
        for (int i = 0; i < 4; i++) expWr(2'd2, 5'(20 + i), 32'h2000 + i);
        for (int i = 0; i < 6; i++) begin
            iWB_VALID = 1'b1;
            iWB_SEL   = 5'(10 + i);
            iWB_DATA  = 32'h1000 + i;
            iLD_VALID = (i < 5);
            iLD_SEL   = 5'(20 + i);
            iLD_DATA  = 32'h2000 + i;
            mid();
            if (i == 4) begin
                chk("t2 full oLD_READY", 32'(oLD_READY), 0);
                chk("t2 full count", 32'(oLD_COUNT), 4);
            end
            tick();
        end
        idle();
        for (int j = 0; j < 4; j++) begin
            mid();
            chk("t2 drain count", 32'(oLD_COUNT), 32'(4 - j));
            tick();
        end
        mid();
        chk("t2 empty count", 32'(oLD_COUNT), 0);
        tick();

        // starvation: host wins on its 9th waiting cycle
        for (int k = 0; k < 8; k++) expWr(2'd2, 5'(k + 1), 32'h3000 + k);
        expWr(2'd3, 5'd7, 32'hC0FFEE00);
        expWr(2'd2, 5'd9, 32'h3008);
        expWr(2'd2, 5'd10, 32'h3009);
        expWr(2'd3, 5'd8, 32'hC0FFEE01);
        iLD_VALID = 1'b1;
        iLD_SEL   = 5'd1;
        iLD_DATA  = 32'h3000;
        tick();
        for (int k = 1; k <= 9; k++) begin
            iLD_VALID   = 1'b1;
            iLD_SEL     = 5'(k + 1);
            iLD_DATA    = 32'h3000 + k;
            iHOST_VALID = 1'b1;
            iHOST_SEL   = 5'd7;
            iHOST_DATA  = 32'hC0FFEE00;
            mid();
            chk($sformatf("t3 host ready wait %0d", k),
                32'(oHOST_READY), 32'(k == 9));
            tick();
        end
        iLD_VALID  = 1'b0;
        iHOST_SEL  = 5'd8;
        iHOST_DATA = 32'hC0FFEE01;
        for (int k = 0; k < 3; k++) begin
            mid();
            chk($sformatf("t3 rewait %0d", k), 32'(oHOST_READY), 32'(k == 2));
            tick();
        end
        idle();

        // two loads to r3 keep pend[3] until the second pops
        expWr(2'd1, 5'd1, 32'h44440001);
        expWr(2'd1, 5'd2, 32'h44440002);
        expWr(2'd2, 5'd3, 32'hD1D1D1D1);
        expWr(2'd2, 5'd3, 32'hD2D2D2D2);
        iWB_VALID = 1'b1;
        iWB_SEL   = 5'd1;
        iWB_DATA  = 32'h44440001;
        iLD_VALID = 1'b1;
        iLD_SEL   = 5'd3;
        iLD_DATA  = 32'hD1D1D1D1;
        tick();
        iWB_SEL   = 5'd2;
        iWB_DATA  = 32'h44440002;
        iLD_DATA  = 32'hD2D2D2D2;
        tick();
        idle();
        mid();
        chk("t4 pend two", oLDPEND, 32'h8);
        tick();
        mid();
        chk("t4 pend one", oLDPEND, 32'h8);
        tick();
        mid();
        chk("t4 pend none", oLDPEND, 0);
        tick();

        // WB beats a queued load and a valid host
        expWr(2'd1, 5'd11, 32'h55550001);
        expWr(2'd1, 5'd13, 32'h55550002);
        expWr(2'd2, 5'd12, 32'hE1E1E1E1);
        expWr(2'd3, 5'd14, 32'h66660000);
        iWB_VALID = 1'b1;
        iWB_SEL   = 5'd11;
        iWB_DATA  = 32'h55550001;
        iLD_VALID = 1'b1;
        iLD_SEL   = 5'd12;
        iLD_DATA  = 32'hE1E1E1E1;
        tick();
        iLD_VALID   = 1'b0;
        iWB_SEL     = 5'd13;
        iWB_DATA    = 32'h55550002;
        iHOST_VALID = 1'b1;
        iHOST_SEL   = 5'd14;
        iHOST_DATA  = 32'h66660000;
        mid();
        chk("t5 oGNT", 32'(oGNT), 1);
        chk("t5 oHOST_READY", 32'(oHOST_READY), 0);
        tick();
        iWB_VALID = 1'b0;
        mid();
        chk("t5 count kept", 32'(oLD_COUNT), 1);
        tick();
        mid();
        chk("t5 host after", 32'(oHOST_READY), 1);
        tick();
        idle();

        // async reset with three loads queued discards them
        for (int i = 0; i < 3; i++) begin
            expWr(2'd1, 5'(16 + i), 32'h77770000 + i);
            iWB_VALID = 1'b1;
            iWB_SEL   = 5'(16 + i);
            iWB_DATA  = 32'h77770000 + i;
            iLD_VALID = 1'b1;
            iLD_SEL   = 5'(24 + i);
            iLD_DATA  = 32'h88880000 + i;
            tick();
        end
        iLD_VALID = 1'b0;
        iWB_SEL   = 5'd19;
        iWB_DATA  = 32'hBAD0BAD0;
        iARESETn  = 1'b0;
        mid();
        chk("t6 rst count", 32'(oLD_COUNT), 0);
        chk("t6 rst oWR", 32'(oWR), 0);
        chk("t6 rst oLDPEND", oLDPEND, 0);
        tick();
        idle();
        iARESETn = 1'b1;
        mid();
        chk("t6 pre-run oLD_READY", 32'(oLD_READY), 0);
        tick();
        mid();
        chk("t6 run oLD_READY", 32'(oLD_READY), 1);
        chk("t6 count after", 32'(oLD_COUNT), 0);
        tick();
        tick();
        mid();

        chk("all writes seen", 32'(expQ.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
